// File: rtl/cache_pkg.sv
// cache_pkg: line geometry and the memory-adapter state type shared by the
// OTTER cache controller and the cache_mem_adapter.
//   s_offset : byte-offset bits per line (line = 2**s_offset bytes)
//   s_line   : line width in bits
//   s_beats  : 32-bit word beats per line
//   BEAT_W   : width of a beat index
package cache_pkg;

  localparam int unsigned s_offset = 5;
  localparam int unsigned s_line   = 8 * (2 ** s_offset);
  localparam int unsigned s_beats  = 2 ** (s_offset - 2);
  localparam int unsigned BEAT_W   = s_offset - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } mem_state_t;

endpackage

// File: rtl/cache_mem_adapter.sv
// cache_mem_adapter: serializes whole-line fills and writebacks from the
// cache into 32-bit word beats on the main-memory word port, and gathers
// fill beats into a registered line buffer returned to the cache.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cache_read, cache_write  line requests, held until cache_resp
//   cache_addr               line address (offset bits ignored)
//   cache_wdata              writeback line, word k = bits [32k+31:32k]
//   cache_rdata              registered fill line buffer
//   cache_resp               one-cycle completion pulse
//   mem_addr, mem_wdata      current beat word address / write word
//   mem_rd, mem_we           word request, held until mem_ack
//   mem_rdata, mem_ack       memory read word / beat complete
module cache_mem_adapter
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cache_read,
  input  logic              cache_write,
  input  logic [31:0]       cache_addr,
  input  logic [s_line-1:0] cache_wdata,
  output logic [s_line-1:0] cache_rdata,
  output logic              cache_resp,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_rd,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  mem_state_t              r_state;
  mem_state_t              w_next_state;
  logic [BEAT_W-1:0]       r_beat;
  logic [31-s_offset:0]    r_addr;
  logic [s_line-1:0]       r_wdata;
  logic [s_line-1:0]       r_rdata;

  logic                    w_last_beat;
  logic [BEAT_W+4:0]       w_bit_base;
  logic                    w_unused;

  // Byte-offset bits of the line address carry no information here.
  assign w_unused    = ^cache_addr[s_offset-1:0];

  assign w_last_beat = (r_beat == BEAT_W'(s_beats - 1));
  assign w_bit_base  = {r_beat, 5'd0};

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: begin
        if (cache_write)     w_next_state = WRITE;
        else if (cache_read) w_next_state = READ;
      end
      WRITE: if (mem_ack && w_last_beat) w_next_state = RESP;
      READ:  if (mem_ack && w_last_beat) w_next_state = RESP;
      RESP:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Memory-side outputs depend only on registered state, never on cache_*.
  always_comb begin
    mem_rd     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    cache_resp = 1'b0;
    unique case (r_state)
      WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = {r_addr, r_beat, 2'b00};
        mem_wdata = r_wdata[w_bit_base +: 32];
      end
      READ: begin
        mem_rd   = 1'b1;
        mem_addr = {r_addr, r_beat, 2'b00};
      end
      RESP:    cache_resp = 1'b1;
      default: ;
    endcase
  end

  assign cache_rdata = r_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next_state;
      unique case (r_state)
        IDLE: begin
          if (cache_write) begin
            r_addr  <= cache_addr[31:s_offset];
            r_wdata <= cache_wdata;
            r_beat  <= '0;
          end else if (cache_read) begin
            r_addr  <= cache_addr[31:s_offset];
            r_beat  <= '0;
          end
        end
        WRITE: begin
          if (mem_ack) r_beat <= w_last_beat ? '0 : r_beat + BEAT_W'(1);
        end
        READ: begin
          if (mem_ack) begin
            r_rdata[w_bit_base +: 32] <= mem_rdata;
            r_beat <= w_last_beat ? '0 : r_beat + BEAT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_mem_adapter.sv
// Scoreboard bench for cache_mem_adapter: the driver pushes the expected
// beat sequence and expected returned line for each transaction; monitors
// compare against whatever the DUT presents on the memory and cache ports.
module tb_cache_mem_adapter;
  import cache_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cache_read = 1'b0;
  logic              cache_write = 1'b0;
  logic [31:0]       cache_addr = '0;
  logic [s_line-1:0] cache_wdata = '0;
  logic [s_line-1:0] cache_rdata;
  logic              cache_resp;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_rd;
  logic              mem_we;
  logic [31:0]       mem_rdata = '0;
  logic              mem_ack = 1'b0;

  cache_mem_adapter dut (
    .clk(clk), .rst(rst),
    .cache_read(cache_read), .cache_write(cache_write),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata),
    .cache_rdata(cache_rdata), .cache_resp(cache_resp),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_beat_t;

  exp_beat_t         beat_q[$];
  logic [255:0]      resp_q[$];
  logic [255:0]      last_line = '0;
  logic [31:0]       ref_mem[logic [31:0]];   // reference view of memory
  logic [31:0]       mem[logic [31:0]];       // responder's memory
  int                ack_mode = 0;            // 0 always, 1 every 3rd cycle, 2 random
  int                errors = 0;
  int                checks = 0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0FFEE00;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder.
  always begin
    @(posedge clk);
    #2;
    mem_ack = 1'b0;
    if (!rst && (mem_rd || mem_we)) begin
      case (ack_mode)
        0: mem_ack = 1'b1;
        1: mem_ack = (cyc % 3 == 0);
        default: mem_ack = ($urandom_range(0, 2) == 0);
      endcase
    end
    mem_rdata = 32'hDEAD_BEEF;
    if (mem_ack && mem_rd)
      mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : dflt(mem_addr);
    if (mem_ack && mem_we)
      mem[mem_addr] = mem_wdata;
  end

  // Monitor.
  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_resp = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_req  = 1'b0;
      prev_resp = 1'b0;
    end else begin
      if (mem_rd || mem_we) begin
        chk("rd_we_exclusive", {mem_rd, mem_we}, mem_rd ? 2'b10 : 2'b01);
        if (prev_req && !prev_ack) begin
          chk("wait_addr_stable", mem_addr, prev_addr);
          chk("wait_wdata_stable", mem_wdata, prev_wdata);
        end
        if (mem_ack) begin
          if (beat_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: got addr %h, none expected", mem_addr);
          end else begin
            exp_beat_t e;
            e = beat_q.pop_front();
            chk("beat_we", mem_we, e.is_we);
            chk("beat_rd", mem_rd, !e.is_we);
            chk("beat_addr", mem_addr, e.addr);
            if (e.is_we) chk("beat_wdata", mem_wdata, e.wdata);
          end
        end
      end
      if (cache_resp) begin
        if (prev_resp) begin
          checks++; errors++;
          $display("FAIL resp_width: got 2 consecutive resp cycles, required 1");
        end
        if (resp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: got resp, none expected");
        end else begin
          chk("resp_rdata", cache_rdata, resp_q.pop_front());
        end
      end
      prev_req   = mem_rd || mem_we;
      prev_ack   = mem_ack;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
      prev_resp  = cache_resp;
    end
  end

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = $urandom;
    return l;
  endfunction

  // One line transaction: compute expectations, raise request, wait for resp.
  task automatic txn(input bit wr, input bit also_rd, input logic [31:0] addr,
                     input logic [255:0] line, output int lat);
    logic [31:0]  base, a, w;
    logic [255:0] eline;
    exp_beat_t    e;
    bit           got;
    base = {addr[31:5], 5'd0};
    eline = '0;
    for (int k = 0; k < 8; k++) begin
      a = base + 32'(4 * k);
      if (wr) begin
        e.is_we = 1'b1; e.addr = a; e.wdata = line[32*k +: 32];
        ref_mem[a] = line[32*k +: 32];
      end else begin
        w = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
        eline[32*k +: 32] = w;
        e.is_we = 1'b0; e.addr = a; e.wdata = '0;
      end
      beat_q.push_back(e);
    end
    if (!wr) last_line = eline;
    resp_q.push_back(last_line);

    @(posedge clk); #1;
    cache_write = wr;
    cache_read  = !wr || also_rd;
    cache_addr  = addr;
    cache_wdata = wr ? line : rand_line();
    lat = 0; got = 0;
    while (!got && lat < 300) begin
      @(negedge clk);
      lat++;
      if (cache_resp) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL resp_timeout: got no resp in %0d cycles, required one", lat);
    end
    @(posedge clk); #1;
    cache_read = 1'b0;
    cache_write = 1'b0;
  endtask

  initial begin
    int           lat;
    logic [255:0] l;
    bit           hit;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_resp", cache_resp, 1'b0);
    chk("reset_rdata", cache_rdata, '0);
    chk("reset_mem_rd", mem_rd, 1'b0);
    chk("reset_mem_we", mem_we, 1'b0);
    chk("reset_mem_addr", mem_addr, '0);
    chk("reset_mem_wdata", mem_wdata, '0);

    // Fill with ack tied high, known word contents.
    ack_mode = 0;
    for (int k = 0; k < 8; k++) begin
      ref_mem[32'h1220 + 32'(4 * k)] = 32'hA0 + 32'(k);
      mem[32'h1220 + 32'(4 * k)]     = 32'hA0 + 32'(k);
    end
    txn(0, 0, 32'h0000_1234, '0, lat);
    chk("fill_latency", lat, 10);

    // Writeback with ack every third cycle.
    ack_mode = 1;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = 32'h1111_0000 + 32'(k);
    txn(1, 0, 32'h8000_00E0, l, lat);

    // Both requests high: only the write is taken, then read it back.
    ack_mode = 0;
    txn(1, 1, 32'h0000_0500, rand_line(), lat);
    txn(0, 0, 32'h0000_0500, '0, lat);

    // Reset during read beat 4 aborts the fill.
    begin
      exp_beat_t e;
      e.is_we = 1'b0; e.wdata = '0;
      for (int k = 0; k < 8; k++) begin
        e.addr = 32'h4000 + 32'(4 * k);
        beat_q.push_back(e);
      end
      @(posedge clk); #1;
      cache_read = 1'b1;
      cache_addr = 32'h0000_4000;
      hit = 0;
      for (int n = 0; n < 50 && !hit; n++) begin
        @(posedge clk); #1;
        if (mem_rd && mem_addr[4:2] == 3'd4) hit = 1;
      end
      chk("reached_beat4", hit, 1'b1);
      rst = 1'b1;
      cache_read = 1'b0;
      beat_q.delete();
      last_line = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_mem_rd", mem_rd, 1'b0);
      chk("abort_mem_addr", mem_addr, '0);
      chk("abort_rdata", cache_rdata, '0);
      chk("abort_resp", cache_resp, 1'b0);
      repeat (5) @(negedge clk);
    end
    txn(0, 0, 32'h0000_4000, '0, lat);
    chk("post_reset_latency", lat, 10);

    // Back-to-back fills.
    txn(0, 0, 32'h0000_0100, '0, lat);
    txn(0, 0, 32'h0000_0200, '0, lat);
    chk("b2b_latency", lat, 10);

    // Random mix over a small set of lines with random wait states.
    ack_mode = 2;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = 32'h3000 + 32'($urandom_range(0, 7) * 32) + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) txn(1, $urandom_range(0, 1) == 1, a, rand_line(), lat);
      else                          txn(0, 0, a, '0, lat);
    end

    repeat (5) @(negedge clk);
    chk("beat_q_drained", 32'(beat_q.size()), 32'd0);
    chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

endmodule
